seq_mult_16: RTL and testbench
==============================

// Module: seq_mult_16
// PURPOSE
//  - Unsigned 16x16 -> 32-bit shift-and-add multiplier, one partial product per clock.
//  - Downstream consumer of the 16-bit lookahead-carry adder bit_16: instantiates it as the
//    datapath adder (A, B, cin -> sum, cout) and iterates it under an FSM.
//  - Sits between an operand producer and a result consumer; valid/ready on both sides.
// PARAMETERS
//  - WIDTH  16  operand width; only 16 is supported (bit_16 is fixed); any other value -> $error at elaboration
// PORTS
//  - clk        in   1   single clock, all state updates on rising edge
//  - rst_n      in   1   asynchronous, active-low reset
//  - in_valid   in   1   operands a/b valid
//  - in_ready   out  1   block can accept operands (high only in IDLE)
//  - a          in   16  multiplicand, unsigned
//  - b          in   16  multiplier, unsigned
//  - out_valid  out  1   product valid (high only in DONE)
//  - out_ready  in   1   consumer accepts product
//  - product    out  32  a*b, unsigned, registered
// BEHAVIOUR
//  - Reset (async assert, released on clk edge): state=IDLE, in_ready=1, out_valid=0,
//    product=0, cnt=0, internal mcand/acc regs=0. Reset mid-operation aborts; result is dropped.
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - IDLE: in_ready=1. in_valid&in_ready at edge k: mcand<=a, acc<={16'd0,b}, cnt<=0, -> CALC.
//  - CALC: in_ready=0, out_valid=0. bit_16 inputs: A=acc[31:16], B=acc[0]?mcand:16'd0, cin=0.
//    Each edge: acc <= {cout, sum, acc[15:1]}; cnt<=cnt+1. When cnt==15 the iteration is the
//    16th: product <= next acc value, -> DONE. cnt is 4 bits; wraps to 0, no overflow use.
//  - Latency: operands accepted at edge k -> out_valid high after edge k+16 (16 CALC cycles).
//  - DONE: out_valid=1, product stable. Held indefinitely while out_ready=0 (no overwrite,
//    in_ready stays 0). out_valid&out_ready at an edge -> IDLE, out_valid=0 next cycle.
//  - No same-cycle accept in DONE: new operands only in IDLE. Throughput: one result / 18 cycles
//    with out_ready tied high.
//  - Widths: bit_16 cout is bit 31 of the shifted acc; no result bit is lost, product < 2^32.
//  - a, b sampled only at accept; changes while busy are ignored. in_valid while busy is ignored
//    (producer must hold it until in_ready).
//  - product keeps its last value in IDLE/CALC; only out_valid qualifies it.
//  - bit_16 p/g outputs left unconnected.
// STRUCTURE
//  - Shared package/header: state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
//    ITER_LAST=4'd15. No typedefs beyond these constants.
//  - One sub-module: bit_16 (existing 16-bit lookahead-carry adder), single instance.
//  - Top holds FSM, counter, acc/mcand registers and B-operand mux; no other hierarchy.
// TESTING
//  - Reset: rst_n low mid-cycle -> outputs immediately in_ready=1, out_valid=0, product=0.
//  - a=1005, b=69 -> product=69345 (0x00010EE1), out_valid exactly 16 cycles after accept.
//  - a=65535, b=65535 -> product=4294836225 (0xFFFE0001); checks carry into bit 31.
//  - a=58135, b=3592 -> product=208820920; a=0, b=50 -> product=0; a=50, b=0 -> product=0.
//  - Backpressure: out_ready low 5 cycles after out_valid -> product/out_valid held,
//    in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
//  - Abort: rst_n low at CALC cycle 8, then new op a=3, b=7 -> product=21, no stale result.
//  - Random: 1000 back-to-back ops, out_ready random -> every product == a*b from a reference model.

Source files
------------

// File: rtl/seq_mult_16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_16_pkg
// Brief    : Shared state encodings and iteration bound for seq_mult_16.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_16_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter value during the 16th (final) shift-and-add step.
    localparam logic [3:0] ITER_LAST = 4'd15;

endpackage
`default_nettype wire

// File: rtl/seq_mult_16_bit_16.sv
`default_nettype none
// ============================================================================
// Module   : bit_16
// Brief    : 16-bit two-level carry-lookahead adder (4 groups of 4 bits).
// Revision : 1.0 - initial release
// ============================================================================
module bit_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic        p,
    output logic        g
);

    logic [15:0] w_bp;
    logic [15:0] w_bg;
    logic [3:0]  w_gp;
    logic [3:0]  w_gg;
    logic [4:0]  w_gc;

    assign w_bp = a ^ b;
    assign w_bg = a & b;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_group
            logic [3:0] w_p;
            logic [3:0] w_g;
            logic [3:0] w_c;

            assign w_p = w_bp[4*gi +: 4];
            assign w_g = w_bg[4*gi +: 4];

            assign w_gp[gi] = &w_p;
            assign w_gg[gi] = w_g[3]
                            | (w_p[3] & w_g[2])
                            | (w_p[3] & w_p[2] & w_g[1])
                            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

            // In-group carries all derive from the group carry-in in one level.
            assign w_c = {
                w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_gc[gi]),
                w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_gc[gi]),
                w_g[0] | (w_p[0] & w_gc[gi]),
                w_gc[gi]
            };

            assign sum[4*gi +: 4] = w_p ^ w_c;
        end
    endgenerate

    assign w_gc[0] = cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & cin);

    assign g = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
             | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
    assign p = &w_gp;

    assign w_gc[4] = g | (p & cin);
    assign cout    = w_gc[4];

endmodule
`default_nettype wire

// File: rtl/seq_mult_16.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_16
// Brief    : Unsigned 16x16->32 shift-and-add multiplier, one partial product
//            per clock, valid/ready handshake on operands and product.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_16
    import seq_mult_16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    generate
        if (WIDTH != 16) begin : g_width_check
            $error("seq_mult_16: WIDTH must be 16 (bit_16 adder is fixed width)");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [3:0]           r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic                 w_unused_p;
    logic                 w_unused_g;

    // Multiplier bits sit in the low half of acc and are consumed LSB-first.
    assign w_addend  = r_acc[0] ? r_mcand : '0;
    assign w_acc_nxt = {w_cout, w_sum, r_acc[WIDTH-1:1]};

    bit_16 u_adder (
        .a    (r_acc[2*WIDTH-1:WIDTH]),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout),
        .p    (w_unused_p),
        .g    (w_unused_g)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == ITER_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_acc   <= {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == ITER_LAST) begin
                        r_product <= w_acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_16
// Brief    : Self-checking bench for seq_mult_16 against an a*b reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int n_checks;
    int n_errors;

    seq_mult_16 #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand16();
        case ($urandom_range(0, 9))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One operation with a hold of 'hold' cycles of consumer backpressure.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input int hold, input string tag);
        logic [31:0] exp_p;
        int          lat;
        int          waitc;
        exp_p = 32'(ta) * 32'(tb_v);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(16));
        check({tag, "_product"}, 64'(product), 64'(exp_p));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
            check({tag, "_hold_out_valid"}, 64'(out_valid), 64'(1));
            check({tag, "_hold_product"}, 64'(product), 64'(exp_p));
            in_valid = (i % 2 == 0);
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check({tag, "_held_product"}, 64'(product), 64'(exp_p));
            check({tag, "_held_out_valid"}, 64'(out_valid), 64'(1));
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_release_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_release_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_product_kept"}, 64'(product), 64'(exp_p));
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] exp_v;
        int          done;
        int          cyc;
        logic        take;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_product", 64'(product), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'd1005,  16'd69,    0, "op_1005x69");
        run_op(16'd65535, 16'd65535, 0, "op_max");
        run_op(16'd58135, 16'd3592,  0, "op_58135x3592");
        run_op(16'd0,     16'd50,    0, "op_0x50");
        run_op(16'd50,    16'd0,     0, "op_50x0");
        run_op(16'd1005,  16'd69,    5, "op_backpressure");

        // Abort mid-calculation; product from the previous op must be cleared.
        a        = 16'd1000;
        b        = 16'd1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_product", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'd3, 16'd7, 0, "abort_next_op");

        // Random back-to-back traffic with random consumer stalls.
        done     = 0;
        cyc      = 0;
        take     = 1'b0;
        in_valid = 1'b0;
        while (done < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (take || !in_valid) begin
                in_valid = ($urandom_range(0, 7) != 0);
                a        = rand16();
                b        = rand16();
                take     = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(a) * 32'(b));
                take = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_result", 64'(1), 64'(0));
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rnd_product", 64'(product), 64'(exp_v));
                end
                done++;
            end
        end
        check("rnd_ops_completed", 64'(done), 64'(1000));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
